// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: greedy change payout over four coin hoppers with inventory tracking and jam detection.
// Define CHANGE_AUDIT_EN to add the audit_total_o running payout counter.
module change_dispense_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int INV_W          = 8,
   parameter int INV_INIT       = 20
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             req_valid_i,
   input  logic [7:0]       req_amount_i,
   output logic             req_ready_o,
   output logic [3:0]       eject_o,
   input  logic [3:0]       hopper_ack_i,
   input  logic             refill_valid_i,
   input  logic [1:0]       refill_sel_i,
   input  logic [INV_W-1:0] refill_count_i,
   output logic             done_o,
   output logic [7:0]       short_amount_o,
   output logic [3:0]       fault_o,
   output logic [3:0]       inv_empty_o
`ifdef CHANGE_AUDIT_EN
   ,
   output logic [15:0]      audit_total_o
`endif
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, DONE} state_t;

   function automatic logic [7:0] val(input logic [1:0] d);
      return d == 2'd3 ? 8'd100 : d == 2'd2 ? 8'd50 : d == 2'd1 ? 8'd20 : 8'd10;
   endfunction

   state_t           state_q, state_d;
   logic [7:0]       rem_q, rem_d;
   logic [1:0]       sel_q, sel_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [3:0]       fault_q, fault_d;
   logic [3:0]       eject_q, eject_d;
   logic             done_q;
   logic [7:0]       short_q;
   logic [INV_W-1:0] inv_q [4];
   logic [INV_W-1:0] inv_d [4];
   logic [INV_W:0]   sum [4];
   logic             found, ack, tout;
   logic [1:0]       pick;

   assign ack  = state_q == WAIT_ACK && hopper_ack_i[sel_q];
   assign tout = state_q == WAIT_ACK && !ack && tmr_q == TW'(TIMEOUT_CYCLES - 1);

   // Ascending scan so the largest usable denomination wins.
   always_comb begin
      found = 1'b0;
      pick  = 2'd0;
      for (int i = 0; i < 4; i++)
         if (inv_q[i] != '0 && val(2'(i)) <= rem_q) begin
            found = 1'b1;
            pick  = 2'(i);
         end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      sel_d   = sel_q;
      tmr_d   = tmr_q;
      fault_d = fault_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            rem_d   = req_amount_i;
            state_d = SELECT;
         end
         SELECT: begin
            sel_d   = found ? pick : sel_q;
            state_d = found ? EJECT : DONE;
         end
         EJECT: begin
            tmr_d   = '0;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: if (ack) begin
            rem_d   = rem_q - val(sel_q);
            state_d = SELECT;
         end else if (tout) begin
            fault_d[sel_q] = 1'b1;
            state_d        = SELECT;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      eject_d = state_d == EJECT ? 4'b0001 << sel_d : 4'b0000;
   end

   // A selected hopper always holds at least one coin, so the decrement cannot underflow.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         sum[i]   = {1'b0, inv_q[i]}
                  + ((refill_valid_i && refill_sel_i == 2'(i)) ? {1'b0, refill_count_i} : '0)
                  - {{INV_W{1'b0}}, ack && sel_q == 2'(i)};
         inv_d[i] = (tout && sel_q == 2'(i)) ? '0 : sum[i][INV_W] ? '1 : sum[i][INV_W-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         rem_q   <= '0;
         sel_q   <= '0;
         tmr_q   <= '0;
         fault_q <= '0;
         eject_q <= '0;
         done_q  <= 1'b0;
         short_q <= '0;
         for (int i = 0; i < 4; i++) inv_q[i] <= INV_W'(INV_INIT);
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sel_q   <= sel_d;
         tmr_q   <= tmr_d;
         fault_q <= fault_d;
         eject_q <= eject_d;
         done_q  <= state_d == DONE;
         short_q <= state_d == DONE ? rem_d : short_q;
         for (int i = 0; i < 4; i++) inv_q[i] <= inv_d[i];
      end
   end

   assign req_ready_o    = state_q == IDLE;
   assign eject_o        = eject_q;
   assign done_o         = done_q;
   assign short_amount_o = short_q;
   assign fault_o        = fault_q;

   always_comb
      for (int i = 0; i < 4; i++) inv_empty_o[i] = inv_q[i] == '0;

`ifdef CHANGE_AUDIT_EN
   logic [15:0] audit_q;
   logic [16:0] aud_sum;
   assign aud_sum = {1'b0, audit_q} + {9'b0, val(sel_q)};
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) audit_q <= '0;
      else if (ack)   audit_q <= aud_sum[16] ? 16'hffff : aud_sum[15:0];
   end
   assign audit_total_o = audit_q;
`endif
endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb_change_dispense_ctrl: directed and random payouts checked against a coin-level greedy model.
module tb_change_dispense_ctrl;
   localparam int T = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [7:0] req_amount = '0;
   logic       req_ready;
   logic [3:0] eject;
   logic [3:0] hopper_ack = '0;
   logic       refill_valid = 1'b0;
   logic [1:0] refill_sel = '0;
   logic [7:0] refill_count = '0;
   logic       done;
   logic [7:0] short_amount;
   logic [3:0] fault;
   logic [3:0] inv_empty;
`ifdef CHANGE_AUDIT_EN
   logic [15:0] audit_total;
`endif

   int nchk = 0;
   int nerr = 0;
   int mi[4];
   logic [3:0] mf;
   int maud;

   change_dispense_ctrl #(.TIMEOUT_CYCLES(T), .INV_W(8), .INV_INIT(20)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .req_valid_i(req_valid), .req_amount_i(req_amount),
      .req_ready_o(req_ready), .eject_o(eject), .hopper_ack_i(hopper_ack),
      .refill_valid_i(refill_valid), .refill_sel_i(refill_sel), .refill_count_i(refill_count),
      .done_o(done), .short_amount_o(short_amount), .fault_o(fault), .inv_empty_o(inv_empty)
`ifdef CHANGE_AUDIT_EN
      , .audit_total_o(audit_total)
`endif
   );

   always #5 clk = ~clk;

   function automatic int val(input int d);
      return d == 3 ? 100 : d == 2 ? 50 : d == 1 ? 20 : 10;
   endfunction

   function automatic int sat(input int x);
      return x > 255 ? 255 : x < 0 ? 0 : x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_status();
      logic [3:0] e;
      for (int d = 0; d < 4; d++) e[d] = mi[d] == 0;
      chk("fault", 32'(fault), 32'(mf));
      chk("inv_empty", 32'(inv_empty), 32'(e));
`ifdef CHANGE_AUDIT_EN
      chk("audit_total", 32'(audit_total), maud);
`endif
   endtask

   task automatic model_reset();
      for (int d = 0; d < 4; d++) mi[d] = 20;
      mf = '0;
      maud = 0;
   endtask

   task automatic refill(input int sel, input int cnt);
      refill_valid = 1'b1;
      refill_sel   = 2'(sel);
      refill_count = 8'(cnt);
      @(posedge clk); #1;
      refill_valid = 1'b0;
      mi[sel] = sat(mi[sel] + cnt);
      chk_status();
   endtask

   // jam: hoppers that never ack; dly: ack delay after eject; rsel>=0 refills rcnt on the first ack of rsel.
   task automatic do_req(input int amt, input logic [3:0] jam, input int dly, input int rsel, input int rcnt);
      int exp_q[$];
      int rem, p, c, cd, dsel, nxt, n, bound;
      bit got, rp;
      rem = amt;
      rp  = rsel >= 0;
      for (int k = 0; k < 64; k++) begin
         p = -1;
         for (int d = 0; d < 4; d++) if (mi[d] > 0 && val(d) <= rem) p = d;
         if (p < 0) break;
         exp_q.push_back(p);
         if (jam[p]) begin
            mf[p] = 1'b1;
            mi[p] = 0;
         end else begin
            rem -= val(p);
            maud = maud + val(p) > 65535 ? 65535 : maud + val(p);
            if (rp && p == rsel) begin
               mi[p] = sat(mi[p] + rcnt - 1);
               rp = 0;
            end else mi[p]--;
         end
      end
      chk("req_ready", 32'(req_ready), 1);
      req_valid  = 1'b1;
      req_amount = 8'(amt);
      rp    = rsel >= 0;
      bound = 40 * (T + 4) + 10;
      n = 0; nxt = 2; cd = 0; dsel = 0; got = 0;
      for (c = 1; c <= bound && !got; c++) begin
         @(posedge clk); #1;
         req_valid    = 1'b0;
         hopper_ack   = '0;
         refill_valid = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               hopper_ack = 4'b0001 << dsel;
               if (rp && dsel == rsel) begin
                  refill_valid = 1'b1;
                  refill_sel   = 2'(rsel);
                  refill_count = 8'(rcnt);
                  rp = 0;
               end
            end
         end
         if (eject !== 4'b0000) begin
            for (int d = 0; d < 4; d++) if (eject[d] === 1'b1) dsel = d;
            chk("eject_onehot", $countones(eject), 1);
            chk("eject_denom", dsel, n < exp_q.size() ? exp_q[n] : -1);
            chk("eject_cycle", c, nxt);
            if (jam[dsel]) nxt = c + T + 2;
            else begin
               cd  = dly;
               nxt = c + dly + 2;
            end
            n++;
         end
         if (done === 1'b1) begin
            got = 1;
            chk("done_cycle", c, nxt);
            chk("short_amount", 32'(short_amount), rem);
         end
      end
      chk("done_seen", 32'(got), 1);
      chk("eject_count", n, exp_q.size());
      @(posedge clk); #1;
      hopper_ack   = '0;
      refill_valid = 1'b0;
      chk("done_one_cycle", 32'(done), 0);
      chk("ready_again", 32'(req_ready), 1);
      chk_status();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_eject", 32'(eject), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_short", 32'(short_amount), 0);
      chk_status();
      reset_n = 1'b1;
      @(posedge clk); #1;

      do_req(180, 4'b0000, 2, -1, 0);
      chk("tp180_inv_empty", 32'(inv_empty), 0);
      do_req(75, 4'b0000, 1, -1, 0);
      do_req(0, 4'b0000, 1, -1, 0);
      while (mi[0] > 0) do_req(10, 4'b0000, 1, -1, 0);
      chk("drained_10c", 32'(inv_empty[0]), 1);
      do_req(60, 4'b0000, 2, -1, 0);
      chk("short_60", 32'(short_amount), 10);

      refill(0, 3);
      do_req(10, 4'b0000, 2, 0, 5);
      while (mi[0] > 0) do_req(10, 4'b0000, 1, -1, 0);
      refill(0, 254);
      refill(0, 5);
      while (mi[0] > 0) do_req(10, 4'b0000, 1, -1, 0);
      chk("sat_drained", 32'(inv_empty[0]), 1);

      do_req(100, 4'b1000, 2, -1, 0);
      chk("jam_fault3", 32'(fault[3]), 1);
      chk("jam_empty3", 32'(inv_empty[3]), 1);
      refill(3, 2);
      do_req(100, 4'b0000, 3, -1, 0);
      chk("fault_sticky", 32'(fault[3]), 1);
      do_req(50, 4'b0000, T, -1, 0);

      req_valid  = 1'b1;
      req_amount = 8'd100;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_pre_eject", 32'(eject), 8);
      @(posedge clk); #1;
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("rst_mid_eject", 32'(eject), 0);
      chk("rst_mid_done", 32'(done), 0);
      chk("rst_mid_ready", 32'(req_ready), 1);
      chk_status();
      @(posedge clk); #1;
      chk("rst_hold_done", 32'(done), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_rel_done", 32'(done), 0);
      do_req(10, 4'b0000, 1, -1, 0);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) refill(int'($urandom_range(0, 3)), int'($urandom_range(0, 30)));
         do_req(int'($urandom_range(0, 255)),
                $urandom_range(0, 9) == 0 ? 4'b0001 << $urandom_range(0, 3) : 4'b0000,
                int'($urandom_range(1, 4)),
                $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 3)) : -1,
                int'($urandom_range(0, 20)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/change_dispense_ctrl.md
# change_dispense_ctrl

- Sequences the four coin-return hoppers (10¢, 20¢, 50¢, $1) of the vending machine to pay back a requested change amount.
- Owns per-denomination coin inventory counters and detects jammed hoppers.
- Sits between the vending FSM, which issues a change request after a sale or cancel, and the hopper drivers.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000: cycles to wait for a hopper ack before declaring a jam.
- INV_W, 8: width of each inventory counter.
- INV_INIT, 20: coins per denomination loaded at reset.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  change request valid.
- req_amount  in  8  change to pay, in cents (0–255).
- req_ready  out  1  controller idle, can accept a request.
- eject  out  4  one-cycle eject pulse; bit0 10¢, bit1 20¢, bit2 50¢, bit3 $1.
- hopper_ack  in  4  coin-passed sensor pulse per hopper.
- refill_valid  in  1  inventory refill strobe.
- refill_sel  in  2  refill denomination (0=10¢ … 3=$1).
- refill_count  in  INV_W  coins added.
- done  out  1  one-cycle pulse, request complete.
- short_amount  out  8  unpaid remainder, valid with done.
- fault  out  4  sticky per-hopper jam flags.
- inv_empty  out  4  inventory[d]==0 per denomination.

## Operation
States and transitions:
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_amount into remaining → SELECT.
- SELECT: pick the largest d with value[d] ≤ remaining and inv[d] > 0.
  - If such a d exists → EJECT.
  - Otherwise (remaining==0 or no usable coin) → DONE.
- EJECT: eject[d]=1 for exactly one cycle; clear the timeout counter → WAIT_ACK.
- WAIT_ACK:
  - On hopper_ack[d]: remaining -= value[d]; inv[d] -= 1 → SELECT.
  - If the counter reaches TIMEOUT_CYCLES: set fault[d]; force inv[d]=0 → SELECT.
  - Acks on other bits are ignored.
- DONE: done=1; short_amount=remaining → IDLE.

Arithmetic and counter rules:
- Greedy choice only; no backtracking. Example: 60 with no 10¢ coins pays 50 and reports short 10.
- Sub-10¢ remainders are always reported as short.
- Subtraction of remaining is 8-bit and never underflows, because value[d] ≤ remaining is guaranteed by SELECT.
- inv[d] saturates at 0 and at 2^INV_W−1.
- Refill is accepted in any state: inv[refill_sel] += refill_count, saturating.
- Refill and ack on the same denomination in the same cycle: net +refill_count−1, saturating.
- Refill does not clear fault. Only reset clears fault.
- A faulted hopper is skipped until refilled (inv > 0); refilling makes it eligible again.

Reset:
- Reset mid-operation aborts the request: no done pulse, eject drops immediately.
- Reset values: state IDLE, req_ready=1, eject=0, done=0, short_amount=0, fault=0, inv[*]=INV_INIT, inv_empty=0 (with INV_INIT>0).

## Timing
- eject, done and short_amount are registered. req_ready and inv_empty are decoded from registered state.
- Accept at edge N; SELECT occupies cycle N+1; eject high in cycle N+2.
- The earliest ack is sampled in the cycle after the eject pulse.
- Per coin: SELECT + EJECT + ≥1 WAIT_ACK cycle, so minimum 3 cycles.
- Zero-amount request: done high in cycle N+2; req_ready high again in cycle N+3.
- Timeout fires in the TIMEOUT_CYCLES-th WAIT_ACK cycle without an ack.
- An ack arriving in that same cycle wins and is not counted as a fault.
- req_valid is ignored while req_ready=0. The requester holds req_valid until accepted.
- done is one cycle only.

## Configuration
- CHANGE_AUDIT_EN defined: adds output audit_total (16 bits, cents).
  - Increments by value[d] on each acked coin.
  - Saturates at 65535; cleared only by reset.
- CHANGE_AUDIT_EN undefined: port and logic absent; behaviour otherwise identical.

## Test plan
- Full inventory, request 180, ack each eject after 2 cycles → eject order $1, 50¢, 20¢, 10¢; done with short_amount=0. Inventories 19 each; audit_total=180 if enabled.
- Request 75 → ejects 50¢, 20¢ → done, short_amount=5.
- Drain 10¢ (inv[0]=0, inv_empty[0]=1), request 60 → eject 50¢ only → short_amount=10.
- Request 100, never ack $1 → after TIMEOUT_CYCLES, fault[3]=1 and inv[3]=0. Then two 50¢ ejects acked → short_amount=0.
- Refill 10¢ count 5 in the same cycle as a 10¢ ack with inv[0]=3 → inv[0]=7. With inv at 2^INV_W−2, refill 5 → saturates at 255.
- Assert reset_n low during WAIT_ACK → eject=0, no done, req_ready=1, inv[*]=INV_INIT, fault=0. After release, a request of 10 completes normally.
